gemm_tile_sequencer: RTL and testbench

- Command-driven controller that sequences one tiled matrix-multiply pass through the systolic datapath.
- Per K-tile it loads weights, streams input rows, and flushes the pipeline into the accumulator banks; on the first K-tile it overwrites, on later K-tiles it accumulates.
- After the last K-tile it drains the four accumulator banks to a valid/ready result stream.
- Sits between the host/DMA command interface and the datapath control inputs.

---
 rtl/gemm_tile_sequencer_pkg.sv | 28 ++
 rtl/gemm_tile_sequencer_drain_ctrl.sv | 52 +++++
 rtl/gemm_tile_sequencer.sv | 173 +++++++++++++++++
 tb/tb_gemm_tile_sequencer.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gemm_tile_sequencer_pkg.sv
// Shared configuration and state encoding for the GEMM tile sequencer.
package gemm_tile_sequencer_pkg;

  localparam int SUPER_SYS_ROWS = 16;
  localparam int CORE_ROWS      = 4;
  localparam int CORE_COLS      = 4;
  localparam int ACC_DEPTH      = 64;
  localparam int FLUSH_LAT      = 40;

  typedef enum logic [2:0] {
    IDLE,
    WLOAD,
    WAIT_HI,
    FEED,
    FLUSH,
    DRAIN
  } seq_state_e;

  // Largest of three values; sizes the shared phase counter.
  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

endpackage

// File: rtl/gemm_tile_sequencer_drain_ctrl.sv
// Drain controller: issues accumulator bank reads one beat at a time,
// holds the registered result-valid flag, and flags drain underflow.
module drain_ctrl #(
  parameter int ROW_W = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             active,
  input  logic [ROW_W-1:0] rows,
  input  logic [3:0]       acc_empty,
  input  logic             out_ready,
  output logic [3:0]       accums_rd_en,
  output logic             out_valid,
  output logic             last_beat,
  output logic             err
);

  logic [ROW_W-1:0] rows_left;
  logic             valid_q;
  logic             err_q;
  logic             issue;

  // Read only when the output slot is free or being freed, beats remain and no bank is empty.
  always_comb begin
    issue        = active && (!valid_q || out_ready) && (rows_left != '0) && (acc_empty == '0);
    accums_rd_en = {4{issue}};
    out_valid    = valid_q;
    err          = err_q;
    last_beat    = active && valid_q && out_ready && (rows_left == '0);
  end

  // Beat counter, registered valid (data lands one cycle after the read) and sticky underflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rows_left <= '0;
      valid_q   <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      if (start) begin
        rows_left <= rows;
      end else if (issue) begin
        rows_left <= rows_left - ROW_W'(1);
      end
      valid_q <= issue || (valid_q && !out_ready);
      if (active && (rows_left != '0) && (acc_empty != '0) && !valid_q) begin
        err_q <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/gemm_tile_sequencer.sv
// Command-driven sequencer for one tiled matrix-multiply pass: per K-tile
// weight load, input feed and pipeline flush, then a drain of the banks.
module gemm_tile_sequencer #(
  parameter int SUPER_SYS_ROWS = gemm_tile_sequencer_pkg::SUPER_SYS_ROWS,
  parameter int CORE_ROWS      = gemm_tile_sequencer_pkg::CORE_ROWS,
  parameter int CORE_COLS      = gemm_tile_sequencer_pkg::CORE_COLS,
  parameter int ACC_DEPTH      = gemm_tile_sequencer_pkg::ACC_DEPTH,
  parameter int FLUSH_LAT      = gemm_tile_sequencer_pkg::FLUSH_LAT
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         cmd_valid,
  output logic                         cmd_ready,
  input  logic [$clog2(ACC_DEPTH):0]   cmd_rows,
  input  logic [7:0]                   cmd_ktiles,
  input  logic [CORE_ROWS-2:0]         cmd_if_mux_sel,
  input  logic [CORE_COLS-1:0]         cmd_w_mux_sel,
  input  logic                         ready_for_HI,
  input  logic [3:0]                   acc_empty,
  output logic                         wfetch,
  output logic                         if_en,
  output logic                         store,
  output logic                         overwrite,
  output logic [CORE_ROWS-2:0]         if_mux_sel,
  output logic [CORE_COLS-1:0]         w_mux_sel,
  output logic [3:0]                   accums_rd_en,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic                         busy,
  output logic                         done,
  output logic                         err
);

  import gemm_tile_sequencer_pkg::*;

  localparam int ROW_W = $clog2(ACC_DEPTH) + 1;
  localparam int CNT_W = $clog2(gemm_tile_sequencer_pkg::max3(SUPER_SYS_ROWS, FLUSH_LAT, ACC_DEPTH)) + 1;

  seq_state_e           state, state_d;
  logic [CNT_W-1:0]     cnt, cnt_d;
  logic [7:0]           kt, kt_d;
  logic [7:0]           ktiles_q;
  logic [ROW_W-1:0]     rows_q;
  logic [CORE_ROWS-2:0] if_sel_q;
  logic [CORE_COLS-1:0] w_sel_q;
  logic                 done_q, done_d;
  logic                 accept;
  logic                 drain_start;
  logic                 drain_active;
  logic                 drain_last;

  // Next-state, phase counter, tile counter and datapath strobes.
  always_comb begin
    state_d      = state;
    cnt_d        = cnt;
    kt_d         = kt;
    done_d       = 1'b0;
    drain_start  = 1'b0;
    accept       = (state == IDLE) && cmd_valid;
    cmd_ready    = (state == IDLE);
    busy         = (state != IDLE);
    drain_active = (state == DRAIN);
    wfetch       = (state == WLOAD);
    if_en        = (state == FEED) && ready_for_HI;
    store        = (state == FEED) || (state == FLUSH);
    overwrite    = store && (kt == '0);
    if_mux_sel   = if_sel_q;
    w_mux_sel    = w_sel_q;
    done         = done_q;
    unique case (state)
      IDLE: begin
        if (accept) begin
          kt_d  = '0;
          cnt_d = '0;
          if ((cmd_rows == '0) || (cmd_ktiles == '0)) begin
            done_d = 1'b1;
          end else begin
            state_d = WLOAD;
          end
        end
      end
      WLOAD: begin
        if (cnt == CNT_W'(SUPER_SYS_ROWS - 1)) begin
          cnt_d   = '0;
          state_d = WAIT_HI;
        end else begin
          cnt_d = cnt + CNT_W'(1);
        end
      end
      WAIT_HI: begin
        if (ready_for_HI) state_d = FEED;
      end
      FEED: begin
        if (ready_for_HI) begin
          if (cnt == CNT_W'(rows_q - ROW_W'(1))) begin
            cnt_d   = '0;
            state_d = FLUSH;
          end else begin
            cnt_d = cnt + CNT_W'(1);
          end
        end
      end
      FLUSH: begin
        if (cnt == CNT_W'(FLUSH_LAT - 1)) begin
          cnt_d = '0;
          if (kt != ktiles_q - 8'd1) begin
            kt_d    = kt + 8'd1;
            state_d = WLOAD;
          end else begin
            drain_start = 1'b1;
            state_d     = DRAIN;
          end
        end else begin
          cnt_d = cnt + CNT_W'(1);
        end
      end
      DRAIN: begin
        if (drain_last) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, counters and the registered done pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      kt     <= '0;
      done_q <= 1'b0;
    end else begin
      state  <= state_d;
      cnt    <= cnt_d;
      kt     <= kt_d;
      done_q <= done_d;
    end
  end

  // Command fields captured on acceptance and held until the next one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rows_q   <= '0;
      ktiles_q <= '0;
      if_sel_q <= '0;
      w_sel_q  <= '0;
    end else if (accept) begin
      rows_q   <= cmd_rows;
      ktiles_q <= cmd_ktiles;
      if_sel_q <= cmd_if_mux_sel;
      w_sel_q  <= cmd_w_mux_sel;
    end
  end

  drain_ctrl #(
    .ROW_W (ROW_W)
  ) u_drain (
    .clk          (clk),
    .rst          (rst),
    .start        (drain_start),
    .active       (drain_active),
    .rows         (rows_q),
    .acc_empty    (acc_empty),
    .out_ready    (out_ready),
    .accums_rd_en (accums_rd_en),
    .out_valid    (out_valid),
    .last_beat    (drain_last),
    .err          (err)
  );

endmodule

// File: tb/tb_gemm_tile_sequencer.sv
// Directed self-checking bench for gemm_tile_sequencer.
module tb_gemm_tile_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [6:0] cmd_rows;
  logic [7:0] cmd_ktiles;
  logic [2:0] cmd_if_mux_sel;
  logic [3:0] cmd_w_mux_sel;
  logic       ready_for_HI;
  logic [3:0] acc_empty;
  logic       wfetch, if_en, store, overwrite;
  logic [2:0] if_mux_sel;
  logic [3:0] w_mux_sel;
  logic [3:0] accums_rd_en;
  logic       out_valid, out_ready, busy, done, err;

  int passed = 0;
  int total  = 0;

  // Event counters maintained by the monitor; tasks compare differences.
  int  n_wf = 0, n_if = 0, n_st = 0, n_ow = 0, n_rd = 0, n_beat = 0, n_done = 0;
  int  n_ifbad = 0, n_vdrop = 0, n_rdstall = 0, n_rdbad = 0;
  logic stall_prev = 1'b0;

  gemm_tile_sequencer #(
    .SUPER_SYS_ROWS (16),
    .CORE_ROWS      (4),
    .CORE_COLS      (4),
    .ACC_DEPTH      (64),
    .FLUSH_LAT      (40)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .cmd_valid      (cmd_valid),
    .cmd_ready      (cmd_ready),
    .cmd_rows       (cmd_rows),
    .cmd_ktiles     (cmd_ktiles),
    .cmd_if_mux_sel (cmd_if_mux_sel),
    .cmd_w_mux_sel  (cmd_w_mux_sel),
    .ready_for_HI   (ready_for_HI),
    .acc_empty      (acc_empty),
    .wfetch         (wfetch),
    .if_en          (if_en),
    .store          (store),
    .overwrite      (overwrite),
    .if_mux_sel     (if_mux_sel),
    .w_mux_sel      (w_mux_sel),
    .accums_rd_en   (accums_rd_en),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .busy           (busy),
    .done           (done),
    .err            (err)
  );

  always #5 clk = ~clk;

  // Inputs change 1ns after the rising edge; everything is sampled on the falling edge.
  always @(negedge clk) begin
    if (wfetch) n_wf++;
    if (if_en) n_if++;
    if (store) n_st++;
    if (overwrite) n_ow++;
    if (accums_rd_en == 4'b1111) n_rd++;
    if (accums_rd_en != 4'b1111 && accums_rd_en != 4'b0000) n_rdbad++;
    if (out_valid && out_ready) n_beat++;
    if (done) n_done++;
    if (if_en && !ready_for_HI) n_ifbad++;
    if (stall_prev && !out_valid) n_vdrop++;
    if (out_valid && !out_ready && accums_rd_en != 4'b0000) n_rdstall++;
    stall_prev = out_valid && !out_ready;
  end

  // Offer a command (caller is 1ns past a rising edge); returns 1ns past the accepting edge.
  task automatic issue_cmd(input logic [6:0] r, input logic [7:0] k,
                           input logic [2:0] ifs, input logic [3:0] ws);
    cmd_rows       = r;
    cmd_ktiles     = k;
    cmd_if_mux_sel = ifs;
    cmd_w_mux_sel  = ws;
    cmd_valid      = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  // Count rising edges until done is seen on a falling edge, bounded by budget.
  task automatic wait_done(input int budget, output int cycles, output bit ok);
    cycles = 0;
    ok     = 1'b0;
    while (!ok && cycles < budget) begin
      @(negedge clk);
      if (done) ok = 1'b1;
      else begin
        @(posedge clk); #1;
        cycles++;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    total++; if (cmd_ready !== 1'b1) $display("FAIL reset_cmd_ready: got %0b want 1", cmd_ready); else passed++;
    total++; if ({wfetch, if_en, store, overwrite, out_valid, busy, done, err} !== 8'h00)
      $display("FAIL reset_strobes: got %b want 00000000", {wfetch, if_en, store, overwrite, out_valid, busy, done, err}); else passed++;
    total++; if ({accums_rd_en, if_mux_sel, w_mux_sel} !== 11'd0)
      $display("FAIL reset_vectors: got %b want 0", {accums_rd_en, if_mux_sel, w_mux_sel}); else passed++;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_single_tile();
    int b_wf, b_if, b_st, b_ow, b_rd, b_beat, b_done, cyc;
    bit ok;
    b_wf = n_wf; b_if = n_if; b_st = n_st; b_ow = n_ow; b_rd = n_rd; b_beat = n_beat; b_done = n_done;
    issue_cmd(7'd4, 8'd1, 3'b011, 4'b1100);
    wait_done(1000, cyc, ok);
    total++; if (!ok) $display("FAIL single_done: got timeout want done"); else passed++;
    total++; if (cyc !== 66) $display("FAIL single_latency: got %0d want 66", cyc); else passed++;
    total++; if (n_wf - b_wf !== 16) $display("FAIL single_wfetch: got %0d want 16", n_wf - b_wf); else passed++;
    total++; if (n_if - b_if !== 4) $display("FAIL single_if_en: got %0d want 4", n_if - b_if); else passed++;
    total++; if (n_st - b_st !== 44) $display("FAIL single_store: got %0d want 44", n_st - b_st); else passed++;
    total++; if (n_ow - b_ow !== 44) $display("FAIL single_overwrite: got %0d want 44", n_ow - b_ow); else passed++;
    total++; if (n_rd - b_rd !== 4) $display("FAIL single_rd_en: got %0d want 4", n_rd - b_rd); else passed++;
    total++; if (n_beat - b_beat !== 4) $display("FAIL single_beats: got %0d want 4", n_beat - b_beat); else passed++;
    total++; if (n_done - b_done !== 1) $display("FAIL single_done_width: got %0d want 1", n_done - b_done); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL single_idle: got busy=%0b want 0", busy); else passed++;
  endtask

  task automatic test_multi_tile();
    int b_wf, b_if, b_st, b_ow, b_rd, b_beat, b_bad, cyc;
    bit ok;
    b_wf = n_wf; b_if = n_if; b_st = n_st; b_ow = n_ow; b_rd = n_rd; b_beat = n_beat; b_bad = n_rdbad;
    issue_cmd(7'd8, 8'd3, 3'b101, 4'b1010);
    // A command held while busy must be ignored and must not disturb the selects.
    cmd_rows = 7'd1; cmd_ktiles = 8'd1; cmd_if_mux_sel = 3'b010; cmd_w_mux_sel = 4'b0101;
    cmd_valid = 1'b1;
    repeat (5) @(posedge clk);
    #1 cmd_valid = 1'b0;
    total++; if (cmd_ready !== 1'b0) $display("FAIL multi_cmd_ready: got %0b want 0", cmd_ready); else passed++;
    total++; if (if_mux_sel !== 3'b101) $display("FAIL multi_if_sel: got %b want 101", if_mux_sel); else passed++;
    total++; if (w_mux_sel !== 4'b1010) $display("FAIL multi_w_sel: got %b want 1010", w_mux_sel); else passed++;
    wait_done(2000, cyc, ok);
    total++; if (!ok) $display("FAIL multi_done: got timeout want done"); else passed++;
    total++; if (cyc !== 199) $display("FAIL multi_latency: got %0d want 199", cyc); else passed++;
    total++; if (n_wf - b_wf !== 48) $display("FAIL multi_wfetch: got %0d want 48", n_wf - b_wf); else passed++;
    total++; if (n_if - b_if !== 24) $display("FAIL multi_if_en: got %0d want 24", n_if - b_if); else passed++;
    total++; if (n_st - b_st !== 144) $display("FAIL multi_store: got %0d want 144", n_st - b_st); else passed++;
    total++; if (n_ow - b_ow !== 48) $display("FAIL multi_overwrite: got %0d want 48", n_ow - b_ow); else passed++;
    total++; if (n_rd - b_rd !== 8) $display("FAIL multi_rd_en: got %0d want 8", n_rd - b_rd); else passed++;
    total++; if (n_beat - b_beat !== 8) $display("FAIL multi_beats: got %0d want 8", n_beat - b_beat); else passed++;
    total++; if (n_rdbad - b_bad !== 0) $display("FAIL multi_rd_pattern: got %0d partial reads want 0", n_rdbad - b_bad); else passed++;
    total++; if (if_mux_sel !== 3'b101) $display("FAIL multi_if_sel_hold: got %b want 101", if_mux_sel); else passed++;
  endtask

  task automatic test_feed_stall();
    int b_if, b_bad;
    bit ok;
    logic [3:0] pat;
    pat = 4'b1001;
    b_if = n_if; b_bad = n_ifbad;
    issue_cmd(7'd5, 8'd1, 3'b001, 4'b0001);
    ok = 1'b0;
    for (int c = 0; c < 1000 && !ok; c++) begin
      @(negedge clk);
      if (done) ok = 1'b1;
      @(posedge clk); #1;
      ready_for_HI = pat[c % 4];
    end
    ready_for_HI = 1'b1;
    total++; if (!ok) $display("FAIL stall_done: got timeout want done"); else passed++;
    total++; if (n_if - b_if !== 5) $display("FAIL stall_if_count: got %0d want 5", n_if - b_if); else passed++;
    total++; if (n_ifbad - b_bad !== 0) $display("FAIL stall_if_gate: got %0d ungated want 0", n_ifbad - b_bad); else passed++;
  endtask

  task automatic test_drain_backpressure();
    int b_rd, b_beat, b_vd, b_rs, cyc, w;
    bit ok;
    b_rd = n_rd; b_beat = n_beat; b_vd = n_vdrop; b_rs = n_rdstall;
    issue_cmd(7'd6, 8'd1, 3'b000, 4'b0000);
    w = 0;
    while (n_beat - b_beat < 2 && w < 500) begin
      @(posedge clk); #1;
      w++;
    end
    total++; if (n_beat - b_beat < 2) $display("FAIL bp_start: got %0d beats want 2", n_beat - b_beat); else passed++;
    out_ready = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    total++; if (out_valid !== 1'b1) $display("FAIL bp_hold: got out_valid=%0b want 1", out_valid); else passed++;
    out_ready = 1'b1;
    wait_done(500, cyc, ok);
    total++; if (!ok) $display("FAIL bp_done: got timeout want done"); else passed++;
    total++; if (n_beat - b_beat !== 6) $display("FAIL bp_beats: got %0d want 6", n_beat - b_beat); else passed++;
    total++; if (n_rd - b_rd !== 6) $display("FAIL bp_rd_en: got %0d want 6", n_rd - b_rd); else passed++;
    total++; if (n_vdrop - b_vd !== 0) $display("FAIL bp_valid_drop: got %0d want 0", n_vdrop - b_vd); else passed++;
    total++; if (n_rdstall - b_rs !== 0) $display("FAIL bp_rd_during_stall: got %0d want 0", n_rdstall - b_rs); else passed++;
  endtask

  task automatic test_zero_rows();
    int b_wf, b_if, b_st, b_done;
    b_wf = n_wf; b_if = n_if; b_st = n_st; b_done = n_done;
    issue_cmd(7'd0, 8'd2, 3'b111, 4'b1111);
    @(negedge clk);
    total++; if (done !== 1'b1) $display("FAIL zero_rows_done: got %0b want 1", done); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL zero_rows_busy: got %0b want 0", busy); else passed++;
    @(negedge clk);
    total++; if (done !== 1'b0) $display("FAIL zero_rows_pulse: got %0b want 0", done); else passed++;
    @(posedge clk); #1;
    issue_cmd(7'd3, 8'd0, 3'b000, 4'b0000);
    @(negedge clk);
    total++; if (done !== 1'b1) $display("FAIL zero_kt_done: got %0b want 1", done); else passed++;
    repeat (5) @(posedge clk);
    #1;
    total++; if (n_wf - b_wf + n_if - b_if + n_st - b_st !== 0)
      $display("FAIL zero_activity: got %0d strobe cycles want 0", n_wf - b_wf + n_if - b_if + n_st - b_st); else passed++;
    total++; if (n_done - b_done !== 2) $display("FAIL zero_done_count: got %0d want 2", n_done - b_done); else passed++;
    total++; if (if_mux_sel !== 3'b000) $display("FAIL zero_sel_latch: got %b want 000", if_mux_sel); else passed++;
  endtask

  task automatic test_reset_mid_feed();
    int b_done, b_beat, w, cyc;
    bit ok;
    issue_cmd(7'd8, 8'd2, 3'b110, 4'b0110);
    w = 0;
    do begin
      @(negedge clk);
      w++;
    end while (!if_en && w < 200);
    total++; if (!if_en) $display("FAIL rst_reach_feed: got timeout want if_en"); else passed++;
    b_done = n_done;
    #2 rst = 1'b1;
    #1;
    total++; if (cmd_ready !== 1'b1) $display("FAIL rst_mid_cmd_ready: got %0b want 1", cmd_ready); else passed++;
    total++; if ({wfetch, if_en, store, overwrite, out_valid, busy, done, err} !== 8'h00)
      $display("FAIL rst_mid_outputs: got %b want 00000000", {wfetch, if_en, store, overwrite, out_valid, busy, done, err}); else passed++;
    total++; if ({if_mux_sel, w_mux_sel} !== 7'd0) $display("FAIL rst_mid_sel: got %b want 0", {if_mux_sel, w_mux_sel}); else passed++;
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    total++; if (n_done - b_done !== 0) $display("FAIL rst_no_done: got %0d want 0", n_done - b_done); else passed++;
    b_beat = n_beat;
    issue_cmd(7'd4, 8'd1, 3'b001, 4'b0010);
    wait_done(1000, cyc, ok);
    total++; if (!ok || cyc !== 66) $display("FAIL rst_rerun_latency: got %0d want 66", cyc); else passed++;
    total++; if (n_beat - b_beat !== 4) $display("FAIL rst_rerun_beats: got %0d want 4", n_beat - b_beat); else passed++;
  endtask

  task automatic test_underflow();
    int b_beat, w, cyc;
    bit ok;
    b_beat = n_beat;
    issue_cmd(7'd6, 8'd1, 3'b000, 4'b0000);
    w = 0;
    do begin
      @(negedge clk);
      w++;
    end while (!out_valid && w < 500);
    total++; if (!out_valid) $display("FAIL uf_reach_drain: got timeout want out_valid"); else passed++;
    @(posedge clk); #1;
    acc_empty = 4'b0001;
    repeat (6) @(posedge clk);
    #1;
    total++; if (err !== 1'b1) $display("FAIL uf_err_set: got %0b want 1", err); else passed++;
    total++; if (out_valid !== 1'b0 || busy !== 1'b1) $display("FAIL uf_wait: got valid=%0b busy=%0b want 0 1", out_valid, busy); else passed++;
    acc_empty = 4'b0000;
    wait_done(500, cyc, ok);
    total++; if (!ok) $display("FAIL uf_done: got timeout want done"); else passed++;
    total++; if (n_beat - b_beat !== 6) $display("FAIL uf_beats: got %0d want 6", n_beat - b_beat); else passed++;
    total++; if (err !== 1'b1) $display("FAIL uf_err_sticky: got %0b want 1", err); else passed++;
    rst = 1'b1;
    #1;
    total++; if (err !== 1'b0) $display("FAIL uf_err_clear: got %0b want 0", err); else passed++;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    rst            = 1'b1;
    cmd_valid      = 1'b0;
    cmd_rows       = '0;
    cmd_ktiles     = '0;
    cmd_if_mux_sel = '0;
    cmd_w_mux_sel  = '0;
    ready_for_HI   = 1'b1;
    acc_empty      = 4'b0000;
    out_ready      = 1'b1;
    test_reset();
    test_single_tile();
    test_multi_tile();
    test_feed_stall();
    test_drain_backpressure();
    test_zero_rows();
    test_reset_mid_feed();
    test_underflow();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
